// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing a - b LSB-first,
// one bit per clock, with a single borrow flop.
//
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output `ovf`.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake; a (minuend) and b (subtrahend) sampled on it
//   out_valid, out_ready result handshake
//   diff                (a - b) mod 2^WIDTH
//   borrow              final borrow, 1 iff unsigned a < b
//   busy                high while shifting or holding a result
//   ovf                 signed overflow (SUB_OVF_EN only)
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              br_q, br_d;
  logic              borrow_q, borrow_d;

  logic              bit_d;
  logic              br_next;
  logic [WIDTH-1:0]  res_shift;

`ifdef SUB_OVF_EN
  // Operand MSBs are shifted out of a_q/b_q, so keep a copy for the overflow term.
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  assign bit_d     = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_shift = {bit_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
`ifdef SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      StShift: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_shift;
        br_d  = br_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d  = StDone;
          diff_d   = res_shift;
          borrow_d = br_next;
`ifdef SUB_OVF_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_shift[WIDTH-1]);
`endif
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, handshakes, underflow,
// backpressure, ignored in_valid, asynchronous reset mid-operation, random back-to-back.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] diff;
  logic       borrow;
  logic       busy;
`ifdef SUB_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] r_diff;
  logic       r_borrow;
  int         r_lat;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
`ifdef SUB_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction. Returns at the negedge after the result handshake.
  // gap: cycles of out_ready=0 after out_valid; poke: pulse in_valid while busy.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int gap,
                        input bit poke);
    int n;
    @(negedge clk);
    check("in_ready_idle", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'h11;
    b = 8'h99;
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = poke && (n == 2);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    r_lat = n;
    if (n >= 40) begin
      check("timeout", 16'(n), 16'd8);
      return;
    end
    r_diff   = diff;
    r_borrow = borrow;
    for (int g = 0; g < gap; g++) begin
      in_valid = poke && (g == 0);
      @(negedge clk);
      check("hold_valid", {15'd0, out_valid}, 16'd1);
      check("hold_diff", {8'd0, diff}, {8'd0, r_diff});
      check("hold_borrow", {15'd0, borrow}, {15'd0, r_borrow});
      check("hold_in_ready", {15'd0, in_ready}, 16'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", {15'd0, out_valid}, 16'd0);
    check("in_ready_back", {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] ref9;

    #12;
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_diff", {8'd0, diff}, 16'd0);
    rst_n = 1'b1;

    // Basic
    run_op(8'h5A, 8'h23, 0, 1'b0);
    check("basic_lat", 16'(r_lat), 16'd8);
    check("basic_diff", {8'd0, r_diff}, 16'h37);
    check("basic_borrow", {15'd0, r_borrow}, 16'd0);

    // Underflow and equal operands
    run_op(8'h10, 8'h20, 0, 1'b0);
    check("uf1_diff", {8'd0, r_diff}, 16'hF0);
    check("uf1_borrow", {15'd0, r_borrow}, 16'd1);
    run_op(8'h00, 8'h01, 0, 1'b0);
    check("uf2_diff", {8'd0, r_diff}, 16'hFF);
    check("uf2_borrow", {15'd0, r_borrow}, 16'd1);
    run_op(8'hA5, 8'hA5, 0, 1'b0);
    check("eq_diff", {8'd0, r_diff}, 16'h00);
    check("eq_borrow", {15'd0, r_borrow}, 16'd0);
    // Result must persist through IDLE
    check("idle_keep_diff", {8'd0, diff}, 16'h00);

    // Backpressure with in_valid pokes during SHIFT and DONE
    run_op(8'hC3, 8'h3C, 5, 1'b1);
    check("bp_lat", 16'(r_lat), 16'd8);
    check("bp_diff", {8'd0, r_diff}, 16'h87);
    check("bp_borrow", {15'd0, r_borrow}, 16'd0);
    check("idle_keep_diff2", {8'd0, diff}, 16'h87);

    // Reset at SHIFT cycle 4
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("mrst_diff", {8'd0, diff}, 16'd0);
    check("mrst_borrow", {15'd0, borrow}, 16'd0);
    check("mrst_busy", {15'd0, busy}, 16'd0);
    check("mrst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h03, 8'h01, 0, 1'b0);
    check("post_rst_diff", {8'd0, r_diff}, 16'h02);
    check("post_rst_borrow", {15'd0, r_borrow}, 16'd0);
    check("post_rst_lat", 16'(r_lat), 16'd8);

`ifdef SUB_OVF_EN
    run_op(8'h80, 8'h01, 0, 1'b0);
    check("ovf1_diff", {8'd0, r_diff}, 16'h7F);
    check("ovf1_ovf", {15'd0, ovf}, 16'd1);
    run_op(8'h7F, 8'hFF, 0, 1'b0);
    check("ovf2_diff", {8'd0, r_diff}, 16'h80);
    check("ovf2_ovf", {15'd0, ovf}, 16'd1);
    run_op(8'h05, 8'h03, 0, 1'b0);
    check("ovf3_diff", {8'd0, r_diff}, 16'h02);
    check("ovf3_ovf", {15'd0, ovf}, 16'd0);
`endif

    // Random back-to-back with random out_ready gaps
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, int'($urandom_range(0, 2)), 1'b0);
      check("rand_result", {7'd0, r_borrow, r_diff}, {7'd0, ref9});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
